data_mem: RTL and testbench

Word-organised data memory for the rv32 processor's load/store path.
- Sits between the execute/memory stage and writeback.
- Takes a 32-bit byte address and performs a 32-bit word write when memRW=1.
- Presents the addressed word combinationally on dataR at all times.
- Storage is flop-based so the whole array clears on reset.

---
 rtl/data_mem_pkg.sv | 28 ++
 rtl/data_mem_byte_lane.sv | 30 +++
 rtl/data_mem.sv | 59 +++++
 tb/tb_data_mem.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared widths and address helpers for the word-organised data memory.
package data_mem_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned DEFAULT_DEPTH  = 256;
    localparam int unsigned DEFAULT_LSB    = 2;

    // Word index from a byte address; depth must be a power of two
    function automatic logic [WORD_W-1:0] addr_to_index(
        input logic [WORD_W-1:0] addr,
        input int unsigned       depth,
        input int unsigned       lsb = DEFAULT_LSB
    );
        return (addr >> lsb) & WORD_W'(depth - 1);
    endfunction

    // True when every address bit above the index field is zero
    function automatic logic addr_in_range(
        input logic [WORD_W-1:0] addr,
        input int unsigned       depth,
        input int unsigned       lsb = DEFAULT_LSB
    );
        return (addr >> lsb) < WORD_W'(depth);
    endfunction

endpackage

// File: rtl/data_mem_byte_lane.sv
// One 8-bit slice of the data memory: async clear, gated write, combinational read.
module data_mem_byte_lane
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [BYTE_W-1:0] i_wdata,
    output logic [BYTE_W-1:0] o_rdata_c
);

    logic [BYTE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_idx];

endmodule

// File: rtl/data_mem.sv
// Word-addressed data memory for the load/store path, built from four byte lanes.
// Optional byte-strobe writes are enabled by defining DATA_MEM_BYTE_STROBE_EN.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned ADDR_LSB = DEFAULT_LSB
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] dataW,
    input  logic              memRW,
`ifdef DATA_MEM_BYTE_STROBE_EN
    input  logic [BYTES_PER_WORD-1:0] wstrb,
`endif
    output logic [WORD_W-1:0] dataR
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0]          w_index;
    logic                      w_in_range;
    logic                      w_wr;
    logic [BYTES_PER_WORD-1:0] w_lane_sel;
    logic [BYTES_PER_WORD-1:0] w_lane_we;
    logic [WORD_W-1:0]         w_rd_word;

    assign w_index    = IDX_W'(addr_to_index(addr, DEPTH, ADDR_LSB));
    assign w_in_range = addr_in_range(addr, DEPTH, ADDR_LSB);
    // An unknown memRW must never be taken as a write
    assign w_wr       = (memRW === 1'b1);

`ifdef DATA_MEM_BYTE_STROBE_EN
    assign w_lane_sel = wstrb;
`else
    assign w_lane_sel = '1;
`endif

    assign w_lane_we = {BYTES_PER_WORD{w_wr & w_in_range}} & w_lane_sel;

    for (genvar i = 0; i < BYTES_PER_WORD; i++) begin : g_lane
        data_mem_byte_lane #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_we      (w_lane_we[i]),
            .i_idx     (w_index),
            .i_wdata   (dataW[i*BYTE_W +: BYTE_W]),
            .o_rdata_c (w_rd_word[i*BYTE_W +: BYTE_W])
        );
    end

    // Out-of-range reads return zero rather than an aliased word
    assign dataR = w_in_range ? w_rd_word : '0;

endmodule

// File: tb/tb_data_mem.sv
// Directed-vector bench for data_mem with a queue-based scoreboard and separate monitor.
module tb_data_mem;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] dataW;
    logic        memRW;
    logic [31:0] dataR;
`ifdef DATA_MEM_BYTE_STROBE_EN
    logic [3:0]  wstrb;
`endif

    exp_t q_exp [$];
    event ev_sample;
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 0;

    data_mem dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .dataW (dataW),
        .memRW (memRW),
`ifdef DATA_MEM_BYTE_STROBE_EN
        .wstrb (wstrb),
`endif
        .dataR (dataR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples dataR 1 ns after the stimulus announces a settled read
    initial begin
        exp_t e;
        forever begin
            @(ev_sample);
            #1;
            checks++;
            if (q_exp.size() == 0) begin
                failures++;
                $display("FAIL %s: sample with empty scoreboard, dataR=%h", "scoreboard", dataR);
            end else begin
                e = q_exp.pop_front();
                if (dataR !== e.exp) begin
                    failures++;
                    $display("FAIL %s: dataR=%h expected=%h", e.name, dataR, e.exp);
                end
            end
        end
    end

    task automatic expect_now(input logic [31:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        q_exp.push_back(e);
        ->ev_sample;
    endtask

    // Called just after a negedge; occupies one clock cycle
    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr  = a;
        memRW = 1'b0;
        #1;
        expect_now(exp, name);
        @(negedge clk);
    endtask

    // Called just after a negedge; optionally checks the old word is still shown before the edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit chk_old, input logic [31:0] old, input string name);
        addr  = a;
        dataW = d;
        memRW = 1'b1;
`ifdef DATA_MEM_BYTE_STROBE_EN
        wstrb = s;
`else
        if (s != 4'hF) $display("note: strobe %h ignored in full-word build", s);
`endif
        if (chk_old) begin
            #1;
            expect_now(old, name);
        end
        @(negedge clk);
        memRW = 1'b0;
`ifdef DATA_MEM_BYTE_STROBE_EN
        wstrb = 4'hF;
`endif
    endtask

    initial begin
        rst_n = 1'b1;
        addr  = '0;
        dataW = '0;
        memRW = 1'b0;
`ifdef DATA_MEM_BYTE_STROBE_EN
        wstrb = 4'hF;
`endif
        #2 rst_n = 1'b0;
        #1;
        expect_now(32'h0, "reset_hold_0x0");
        #3;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        rd(32'h0,   32'h0, "reset_rd_0x0");
        rd(32'h8,   32'h0, "reset_rd_0x8");
        rd(32'h3FC, 32'h0, "reset_rd_0x3FC");

        wr(32'h8, 32'd1234, 4'hF, 1'b1, 32'h0, "no_bypass_0x8");
        rd(32'h8, 32'h0000_04D2, "basic_rd_0x8");
        rd(32'hC, 32'h0, "basic_rd_0xC");

        wr(32'hB, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0000_04D2, "no_bypass_0xB");
        rd(32'h8, 32'hDEAD_BEEF, "unaligned_rd_0x8");
        rd(32'hB, 32'hDEAD_BEEF, "unaligned_rd_0xB");

        wr(32'h3FC, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0, "");
        rd(32'h3FC, 32'hA5A5_A5A5, "top_word_0x3FC");
        rd(32'h3F8, 32'h0, "below_top_0x3F8");

        wr(32'h400, 32'h1234_5678, 4'hF, 1'b0, 32'h0, "");
        wr(32'h408, 32'h1234_5678, 4'hF, 1'b0, 32'h0, "");
        wr(32'h8000_0008, 32'h1234_5678, 4'hF, 1'b0, 32'h0, "");
        rd(32'h400, 32'h0, "oor_rd_0x400");
        rd(32'h0,   32'h0, "oor_alias_0x0");
        rd(32'h8,   32'hDEAD_BEEF, "oor_alias_0x8");

        // Async reset in the middle of a cycle, then a write pulsed while held
        wr(32'h10, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, "");
        rd(32'h10, 32'hCAFE_F00D, "fill_0x10");
        addr  = 32'h10;
        #1 rst_n = 1'b0;
        #1;
        expect_now(32'h0, "async_clear_0x10");
        @(negedge clk);
        wr(32'h14, 32'h5555_AAAA, 4'hF, 1'b0, 32'h0, "");
        rd(32'h14, 32'h0, "blocked_wr_in_reset");
        rst_n = 1'b1;
        wr(32'h18, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0, "");
        rd(32'h18, 32'h0BAD_F00D, "first_edge_after_release");
        rd(32'h14, 32'h0, "post_reset_0x14");
        rd(32'h8,  32'h0, "post_reset_0x8");

`ifdef DATA_MEM_BYTE_STROBE_EN
        wr(32'h20, 32'h1122_3344, 4'hF, 1'b0, 32'h0, "");
        rd(32'h20, 32'h1122_3344, "strobe_base");
        wr(32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0, "");
        rd(32'h20, 32'h11BB_33DD, "strobe_0101");
        wr(32'h20, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0, "");
        rd(32'h20, 32'h11BB_33DD, "strobe_0000");
        wr(32'h20, 32'h0000_0000, 4'b1000, 1'b0, 32'h0, "");
        rd(32'h20, 32'h00BB_33DD, "strobe_1000");
`endif

        #4;
        stim_done = 1'b1;
    end

    // Termination: drain the scoreboard, flag leftovers, bound the whole run
    initial begin
        fork
            begin
                wait (stim_done);
                #10;
            end
            begin
                #100000;
                failures++;
                $display("FAIL %s: stimulus did not complete, pending=%0d", "timeout", q_exp.size());
            end
        join_any
        disable fork;
        checks++;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL %s: pending=%0d expected=0", "scoreboard_drain", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
